// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the program-counter sequencer: source selects and FSM states.
package pc_sequencer_pkg;

  localparam logic [2:0] SEL_SEQ  = 3'b000;
  localparam logic [2:0] SEL_JUMP = 3'b001;
  localparam logic [2:0] SEL_JR   = 3'b010;
  localparam logic [2:0] SEL_BR   = 3'b011;
  localparam logic [2:0] SEL_HOLD = 3'b100;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } state_t;

endpackage

// File: rtl/pc_next_mux.sv
// Decodes sel/br_cond into a candidate redirect target, a redirect-request flag and a sequential-advance flag.
// Purely combinational; the top module owns all sequencing.
module pc_next_mux
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2:0]       sel,
  input  logic             br_cond,
  input  logic [WIDTH-1:0] jump_target,
  input  logic [WIDTH-1:0] jr_target,
  input  logic [WIDTH-1:0] br_target,
  output logic [WIDTH-1:0] target,
  output logic             redir_req,
  output logic             advance
);

  always_comb begin
    target    = '0;
    redir_req = 1'b0;
    advance   = 1'b0;
    case (sel)
      SEL_SEQ: advance = 1'b1;
      SEL_JUMP: begin
        target    = jump_target;
        redir_req = 1'b1;
      end
      SEL_JR: begin
        target    = jr_target;
        redir_req = 1'b1;
      end
      SEL_BR: begin
        if (br_cond) begin
          target    = br_target;
          redir_req = 1'b1;
        end else begin
          advance = 1'b1;
        end
      end
      SEL_HOLD: ;
      default: ;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter unit: next-PC selection with stall, latched pending redirect, exception entry and flush pulse.
// Optional target alignment check enabled by defining PC_SEQUENCER_ALIGN_CHECK_EN.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned INC          = 4,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic [2:0]       sel,
  input  logic             br_cond,
  input  logic [WIDTH-1:0] jump_target,
  input  logic [WIDTH-1:0] jr_target,
  input  logic [WIDTH-1:0] br_target,
  input  logic             exc_req,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus_inc,
  output logic [WIDTH-1:0] epc,
  output logic             redirect,
  output logic             pending,
  output logic             align_err
);

  localparam logic [WIDTH-1:0] INC_W   = WIDTH'(INC);
  localparam logic [WIDTH-1:0] RST_PC  = WIDTH'(RESET_VECTOR);
  localparam logic [WIDTH-1:0] EXC_PC  = WIDTH'(EXC_VECTOR);

  state_t           state;
  logic [WIDTH-1:0] pend_target;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] ld_target;
  logic             redir_req;
  logic             advance;
  logic             ld_bad;

  pc_next_mux #(.WIDTH(WIDTH)) u_mux (
    .sel         (sel),
    .br_cond     (br_cond),
    .jump_target (jump_target),
    .jr_target   (jr_target),
    .br_target   (br_target),
    .target      (target),
    .redir_req   (redir_req),
    .advance     (advance)
  );

  assign pc_plus_inc = pc + INC_W;
  assign pending     = (state == ST_PEND);
  // On release of a pending redirect the latched target wins over whatever sel says.
  assign ld_target   = (state == ST_PEND) ? pend_target : target;

`ifdef PC_SEQUENCER_ALIGN_CHECK_EN
  assign ld_bad = |(ld_target & (INC_W - WIDTH'(1)));
`else
  assign ld_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RST_PC;
      epc         <= '0;
      redirect    <= 1'b0;
      align_err   <= 1'b0;
      pend_target <= '0;
      state       <= ST_RUN;
    end else begin
      redirect  <= 1'b0;
      align_err <= 1'b0;
      if (exc_req) begin
        pc       <= EXC_PC;
        epc      <= pc;
        redirect <= 1'b1;
        state    <= ST_RUN;
      end else if (stall) begin
        if (redir_req) begin
          pend_target <= target;
          state       <= ST_PEND;
        end
      end else if (state == ST_PEND || redir_req) begin
        redirect <= 1'b1;
        state    <= ST_RUN;
        if (ld_bad) begin
          pc        <= EXC_PC;
          epc       <= ld_target;
          align_err <= 1'b1;
        end else begin
          pc <= ld_target;
        end
      end else if (advance) begin
        pc <= pc_plus_inc;
      end
    end
  end

endmodule
